dht11_poll_ctrl: RTL and testbench

DHT11_POLL_CTRL -- requirements
Module: dht11_poll_ctrl

---
 rtl/dht11_poll_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_dht11_poll_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dht11_poll_ctrl.sv
// dht11_poll_ctrl
// Arbitrates measurement requests from two requesters, plus an optional
// periodic self-trigger, onto a single DHT11 reader. It enforces the sensor's
// minimum spacing between start_o pulses and times out silent attempts,
// aborting the reader when that happens. Failed attempts are retried a
// bounded number of times. The result is handed back to every requester that
// was pending at trigger time, one round-robin grant per cycle.
//
// Ports
//   clk, rst_n      system clock, asynchronous active-low reset
//   req_i[1:0]      one-cycle request pulse per requester
//   auto_en_i       level, enables periodic self-triggered measurement
//   sensor_ready_i  one-cycle completion pulse from the reader
//   sensor_data_i   {temp_int, hum_int}; 16'h0000 signals a checksum failure
//   start_o         one-cycle trigger to the reader
//   sensor_rst_n_o  active-low reader abort, low for 2 cycles after a timeout
//   gnt_o[1:0]      one-hot, one-cycle result grant
//   data_o          last valid reading
//   data_valid_o    a valid reading has been stored since reset
//   err_o           1 = every attempt of the latest measurement failed
//   busy_o          controller is not in IDLE
//   state_dbg       current FSM state, for observation only
//
// Handshake semantics: there is no back-pressure anywhere. Every *_i pulse
// is sampled on exactly one rising edge, and every output pulse (start_o,
// gnt_o) lasts exactly one cycle. sensor_ready_i is honoured only in WAIT.
module dht11_poll_ctrl #(
  parameter int MIN_INTERVAL = 100_000_000,
  parameter int TIMEOUT      = 2_500_000,
  parameter int MAX_RETRY    = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_i,
  input  logic        auto_en_i,
  input  logic        sensor_ready_i,
  input  logic [15:0] sensor_data_i,
  output logic        start_o,
  output logic        sensor_rst_n_o,
  output logic [1:0]  gnt_o,
  output logic [15:0] data_o,
  output logic        data_valid_o,
  output logic        err_o,
  output logic        busy_o,
  output logic [2:0]  state_dbg
);

  localparam int HW = (MIN_INTERVAL > 0) ? $clog2(MIN_INTERVAL + 1) : 1;
  localparam int TW = (TIMEOUT > 0)      ? $clog2(TIMEOUT + 1)      : 1;
  localparam int RW = (MAX_RETRY > 0)    ? $clog2(MAX_RETRY + 1)    : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    TRIG  = 3'd1,
    WAIT  = 3'd2,
    ABORT = 3'd3,
    HOLD  = 3'd4,
    GRANT = 3'd5
  } state_t;

  state_t          state, state_next;
  logic [HW-1:0]   hold_cnt;
  logic [TW-1:0]   to_cnt;
  logic [RW-1:0]   retry_cnt;
  logic            abort_cnt;
  logic [1:0]      pending;
  logic [1:0]      served;
  logic            rr;
  logic [15:0]     data_q;
  logic            data_valid_q;
  logic            err_q;

  logic            hold_done;
  logic            retries_left;
  logic            fail;
  logic            done_ok;
  logic            pick;
  logic [1:0]      gnt;
  logic [1:0]      served_next;

  assign hold_done    = (hold_cnt == HW'(MIN_INTERVAL));
  assign retries_left = (retry_cnt < RW'(MAX_RETRY));

  // Round-robin pick: the pointer's requester if it is served, else the other.
  assign pick        = served[rr] ? rr : ~rr;
  assign gnt         = (state == GRANT && served != 2'b00) ? (pick ? 2'b10 : 2'b01) : 2'b00;
  assign served_next = served & ~gnt;

  always_comb begin
    state_next = state;
    fail       = 1'b0;
    done_ok    = 1'b0;
    unique case (state)
      IDLE:  if (hold_done && (pending != 2'b00 || auto_en_i)) state_next = TRIG;
      TRIG:  state_next = WAIT;
      WAIT: begin
        // A reply on the expiry cycle wins over the timeout.
        if (sensor_ready_i) begin
          if (sensor_data_i != 16'h0000) begin
            done_ok    = 1'b1;
            state_next = GRANT;
          end else begin
            fail = 1'b1;
          end
        end else if (to_cnt == TW'(TIMEOUT)) begin
          state_next = ABORT;
        end
      end
      ABORT: if (abort_cnt) fail = 1'b1;
      HOLD:  if (hold_done) state_next = TRIG;
      GRANT: if (served_next == 2'b00) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (fail) state_next = retries_left ? HOLD : GRANT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt     <= '0;
      to_cnt       <= '0;
      retry_cnt    <= '0;
      abort_cnt    <= 1'b0;
      pending      <= 2'b00;
      served       <= 2'b00;
      rr           <= 1'b0;
      data_q       <= 16'h0000;
      data_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      // A request arriving with its own grant keeps the bit set.
      pending <= (pending & ~gnt) | req_i;

      // The TRIG cycle itself is the first cycle elapsed since start_o.
      if (state == TRIG) begin
        hold_cnt <= HW'(1);
      end else if (!hold_done) begin
        hold_cnt <= hold_cnt + HW'(1);
      end

      if (state == TRIG) begin
        to_cnt <= '0;
      end else if (state == WAIT && to_cnt != TW'(TIMEOUT)) begin
        to_cnt <= to_cnt + TW'(1);
      end

      abort_cnt <= (state == ABORT) ? 1'b1 : 1'b0;

      if (state == IDLE) begin
        retry_cnt <= '0;
      end else if (fail && retries_left) begin
        retry_cnt <= retry_cnt + RW'(1);
      end

      // Only the first attempt of a measurement captures the requesters;
      // retries keep serving the same set.
      if (state == TRIG && retry_cnt == '0) begin
        served <= pending;
      end else if (state == GRANT) begin
        served <= served_next;
      end

      if (gnt != 2'b00) rr <= ~pick;

      if (done_ok) begin
        data_q       <= sensor_data_i;
        data_valid_q <= 1'b1;
        err_q        <= 1'b0;
      end else if (fail && !retries_left) begin
        err_q <= 1'b1;
      end
    end
  end

  assign start_o        = (state == TRIG);
  assign sensor_rst_n_o = (state != ABORT);
  assign gnt_o          = gnt;
  assign data_o         = data_q;
  assign data_valid_o   = data_valid_q;
  assign err_o          = err_q;
  assign busy_o         = (state != IDLE);
  assign state_dbg      = state;

endmodule

// File: tb/tb_dht11_poll_ctrl.sv
// Testbench for dht11_poll_ctrl. The bench plays the DHT11 reader and both
// requesters. A reference model tracks pending requesters, the round-robin
// pointer and the stored reading, and pushes expected grants into exp_q when
// a measurement's outcome is decided. A separate monitor pops and compares
// whenever gnt_o is non-zero.
module tb_dht11_poll_ctrl;
  localparam int MIN_INTERVAL = 20;
  localparam int TIMEOUT      = 10;
  localparam int MAX_RETRY    = 2;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_i;
  logic        auto_en_i;
  logic        sensor_ready_i;
  logic [15:0] sensor_data_i;
  logic        start_o;
  logic        sensor_rst_n_o;
  logic [1:0]  gnt_o;
  logic [15:0] data_o;
  logic        data_valid_o;
  logic        err_o;
  logic        busy_o;
  logic [2:0]  state_dbg;

  dht11_poll_ctrl #(
    .MIN_INTERVAL(MIN_INTERVAL),
    .TIMEOUT(TIMEOUT),
    .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_i(req_i),
    .auto_en_i(auto_en_i),
    .sensor_ready_i(sensor_ready_i),
    .sensor_data_i(sensor_data_i),
    .start_o(start_o),
    .sensor_rst_n_o(sensor_rst_n_o),
    .gnt_o(gnt_o),
    .data_o(data_o),
    .data_valid_o(data_valid_o),
    .err_o(err_o),
    .busy_o(busy_o),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // counters and model state
  int          n_vec;
  int          n_miss;
  int          cyc;
  int          last_start;
  int          reply_at;
  int          stray_at;
  int          block_until;
  int          exp_aborts;
  int          seen_aborts;
  int          low_run;
  int          m_attempt;
  int          m_rr;
  logic [1:0]  m_pending;
  logic [1:0]  m_served;
  logic [1:0]  block_mask;
  logic [15:0] m_data;
  logic        m_valid;
  logic [15:0] reply_data;
  logic [19:0] exp_q[$];
  int          f_kind_q[$];
  int          f_d_q[$];
  logic [15:0] f_data_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected grants for the served set, in round-robin order.
  task automatic predict_grants(input logic err);
    logic [1:0] s;
    int p;
    s = m_served;
    while (s != 2'b00) begin
      p = s[m_rr] ? m_rr : (m_rr ^ 1);
      exp_q.push_back({m_valid, err, (p == 1) ? 2'b10 : 2'b01, m_data});
      s[p] = 1'b0;
      m_rr = p ^ 1;
    end
  endtask

  task automatic do_reset(input int hold);
    @(negedge clk);
    rst_n = 1'b0;
    req_i = 2'b00;
    auto_en_i = 1'b0;
    sensor_ready_i = 1'b0;
    sensor_data_i = 16'h0000;
    #1;
    check("reset_outputs",
          {start_o, sensor_rst_n_o, gnt_o, data_o, data_valid_o, err_o, busy_o},
          {1'b0, 1'b1, 2'b00, 16'h0000, 1'b0, 1'b0, 1'b0});
    repeat (hold) @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    last_start = 0;
    reply_at = -1;
    stray_at = -1;
    block_until = -1;
    block_mask = 2'b00;
    exp_aborts = 0;
    seen_aborts = 0;
    low_run = 0;
    m_attempt = 0;
    m_rr = 0;
    m_pending = 2'b00;
    m_served = 2'b00;
    m_data = 16'h0000;
    m_valid = 1'b0;
    exp_q.delete();
  endtask

  // driver: one clock cycle of reader and requester behaviour
  // kind: 0 = valid reply, 1 = zero (checksum) reply, 2 = no reply
  task automatic cycle_step(input int req_pct, input logic [1:0] force_r);
    logic [1:0]  r;
    int          kind;
    int          d;
    logic [15:0] x;
    logic        fin;
    @(negedge clk);
    cyc++;
    req_i = 2'b00;
    sensor_ready_i = 1'b0;
    sensor_data_i = 16'h0000;

    if (!sensor_rst_n_o) begin
      low_run++;
    end else if (low_run != 0) begin
      check("abort_len", low_run, 2);
      seen_aborts++;
      low_run = 0;
    end

    if (start_o) begin
      check("start_gap_min", (cyc - last_start) >= MIN_INTERVAL, 1'b1);
      if (auto_en_i) check("start_gap_auto", (cyc - last_start) <= MIN_INTERVAL + 2, 1'b1);
      last_start = cyc;
      if (m_attempt == 0) m_served = m_pending;
      if (f_kind_q.size() != 0) begin
        kind = f_kind_q.pop_front();
        d = f_d_q.pop_front();
        x = f_data_q.pop_front();
      end else begin
        kind = $urandom_range(0, 9);
        kind = (kind < 6) ? 0 : ((kind < 8) ? 1 : 2);
        d = $urandom_range(1, TIMEOUT + 1);
        x = 16'($urandom_range(1, 65535));
      end
      if (kind == 1) x = 16'h0000;
      reply_at = (kind == 2) ? -1 : cyc + d;
      reply_data = x;
      if (kind == 2) begin
        exp_aborts++;
        stray_at = cyc + TIMEOUT + 6;
      end
      fin = (kind == 0) || (m_attempt == MAX_RETRY);
      if (fin) begin
        if (kind == 0) begin
          m_data = x;
          m_valid = 1'b1;
        end
        predict_grants(kind != 0);
        block_mask = m_served;
        block_until = cyc + TIMEOUT + 8;
        m_pending = m_pending & ~m_served;
        m_attempt = 0;
      end else begin
        m_attempt++;
      end
    end

    if (cyc == reply_at) begin
      sensor_ready_i = 1'b1;
      sensor_data_i = reply_data;
    end
    if (cyc == stray_at) begin
      sensor_ready_i = 1'b1;
      sensor_data_i = 16'hBEEF;
    end

    r = force_r;
    if ($urandom_range(0, 99) < req_pct) r = r | 2'($urandom_range(1, 3));
    if (cyc <= block_until) r = r & ~block_mask;
    req_i = r;
    m_pending = m_pending | r;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_pending != 2'b00 || busy_o || cyc <= block_until) && n < 600) begin
      cycle_step(0, 2'b00);
      n++;
    end
    check("drain_bound", n < 600, 1'b1);
    check("idle_after_drain", busy_o, 1'b0);
    check("queue_empty", exp_q.size(), 0);
  endtask

  task automatic push_reply(input int kind, input int d, input logic [15:0] x);
    f_kind_q.push_back(kind);
    f_d_q.push_back(d);
    f_data_q.push_back(x);
  endtask

  // monitor / scoreboard
  initial begin
    logic [19:0] e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && gnt_o != 2'b00) begin
        check("grant_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("grant", {data_valid_o, err_o, gnt_o, data_o}, e);
        end
      end
    end
  end

  // stimulus
  initial begin
    int n;
    n_vec = 0;
    n_miss = 0;
    rst_n = 1'b1;
    req_i = 2'b00;
    auto_en_i = 1'b0;
    sensor_ready_i = 1'b0;
    sensor_data_i = 16'h0000;

    // directed: single request, reply after 5 cycles
    do_reset(3);
    push_reply(0, 5, 16'h1A2D);
    cycle_step(0, 2'b01);
    drain();
    // both requesters, reply on the timeout expiry cycle
    push_reply(0, TIMEOUT + 1, 16'h5A5A);
    cycle_step(0, 2'b11);
    drain();
    push_reply(0, 3, 16'h3C3C);
    cycle_step(0, 2'b11);
    drain();
    // three silent attempts: aborts, then error grant with old data
    push_reply(2, 1, 16'h0000);
    push_reply(2, 1, 16'h0000);
    push_reply(2, 1, 16'h0000);
    cycle_step(0, 2'b01);
    drain();
    // checksum failure then good reply on retry
    push_reply(1, 3, 16'h0000);
    push_reply(0, 4, 16'h0F30);
    cycle_step(0, 2'b10);
    drain();
    // random manual requests
    repeat (1500) cycle_step(4, 2'b00);
    drain();
    check("abort_count_manual", seen_aborts, exp_aborts);

    // auto mode with occasional requests
    do_reset(2);
    auto_en_i = 1'b1;
    repeat (800) cycle_step(2, 2'b00);
    auto_en_i = 1'b0;
    drain();
    check("abort_count_auto", seen_aborts, exp_aborts);

    // reset while waiting for the reader
    do_reset(2);
    push_reply(2, 1, 16'h0000);
    cycle_step(0, 2'b01);
    n = 0;
    while (last_start != cyc && n < 100) begin
      cycle_step(0, 2'b00);
      n++;
    end
    check("reset_test_start", n < 100, 1'b1);
    repeat (3) cycle_step(0, 2'b00);
    do_reset(2);
    cycle_step(0, 2'b10);
    drain();
    check("abort_count_reset", seen_aborts, exp_aborts);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
